// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared types and constants for the NPU AXI responder
package hs_npu_pkg;

    typedef logic [31:0] uword;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_SLVERR = 2'b10
    } axi_resp_t;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_WR_RESP
    } rsp_state_t;

    // A burst is unserviceable if it starts below the window, is not word
    // aligned, or asks for anything other than full 32-bit beats.
    function automatic logic start_err(input uword addr, input uword base,
                                       input logic [2:0] size);
        return (addr < base) || (addr[1:0] != 2'b00) || (size != AXI_SIZE_WORD);
    endfunction

endpackage

// File: rtl/axib_if.sv
// rtl/axib_if.sv - AXI4 burst bundle, 32-bit data, 4-bit strobe
interface axib_if;
    import hs_npu_pkg::*;

    uword        araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    uword        rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    uword        awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    uword        wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport s (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

    modport m (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/hs_npu_sram.sv
// rtl/hs_npu_sram.sv - single-port word SRAM, 1-cycle read, byte-enable write
module hs_npu_sram
    import hs_npu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  uword          wdata,
    output uword          rdata
);

    uword mem_q [DEPTH_WORDS];
    uword rdata_q;

    // Storage is never reset; data out holds between accesses so an
    // unconsumed read result stays available to the responder.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hs_npu_axi_responder.sv
// rtl/hs_npu_axi_responder.sv - AXI4 INCR burst responder backed by internal SRAM
module hs_npu_axi_responder
    import hs_npu_pkg::*;
#(
    parameter int   DEPTH_WORDS = 1024,
    parameter uword BASE_ADDR   = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    axib_if.s    axi
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    rsp_state_t state_q, state_d;
    uword       addr_q, addr_d;
    logic [7:0] len_q, len_d;
    logic [7:0] beat_q, beat_d;
    logic       err_q, err_d;
    logic       issue_done_q, issue_done_d;
    logic       pend_q, pend_d;
    logic       pend_last_q, pend_last_d;
    logic       rvalid_q, rvalid_d;
    logic       rlast_q, rlast_d;
    uword       rdata_q, rdata_d;
    axi_resp_t  rresp_q, rresp_d;
    logic       bvalid_q, bvalid_d;
    axi_resp_t  bresp_q, bresp_d;
    logic       wlast_err_q, wlast_err_d;

    logic          idle_rdy, aw_hs, ar_hs, w_hs, r_hs;
    logic          load, issue, beat_last, wlast_bad;
    logic          sram_en;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    uword          sram_rdata;

    assign idle_rdy    = !rst && (state_q == ST_IDLE);
    assign axi.awready = idle_rdy;
    assign axi.arready = idle_rdy && !axi.awvalid;
    assign axi.wready  = !rst && (state_q == ST_WR_BURST);

    assign aw_hs = axi.awvalid && axi.awready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign r_hs  = rvalid_q && axi.rready;

    // The SRAM output acts as the staging entry: it moves into the output
    // slot when that slot is empty or being emptied, and a new read is only
    // issued when the staged word will have been taken.
    assign load      = pend_q && (!rvalid_q || axi.rready);
    assign issue     = (state_q == ST_RD_BURST) && !issue_done_q && (!pend_q || load);
    assign beat_last = (beat_q == len_q);
    assign wlast_bad = (axi.wlast != beat_last);

    assign sram_en   = issue || w_hs;
    assign sram_we   = (w_hs && !err_q) ? axi.wstrb : 4'b0000;
    assign sram_addr = AW'(((addr_q - BASE_ADDR) >> 2) + uword'(beat_q));

    hs_npu_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (axi.wdata),
        .rdata (sram_rdata)
    );

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        err_d        = err_q;
        issue_done_d = issue_done_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        wlast_err_d  = wlast_err_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_d     = ST_WR_BURST;
                    addr_d      = axi.awaddr;
                    len_d       = axi.awlen;
                    err_d       = start_err(axi.awaddr, BASE_ADDR, axi.awsize);
                    beat_d      = 8'd0;
                    wlast_err_d = 1'b0;
                end else if (ar_hs) begin
                    state_d      = ST_RD_BURST;
                    addr_d       = axi.araddr;
                    len_d        = axi.arlen;
                    err_d        = start_err(axi.araddr, BASE_ADDR, axi.arsize);
                    beat_d       = 8'd0;
                    issue_done_d = 1'b0;
                    pend_d       = 1'b0;
                    pend_last_d  = 1'b0;
                end
            end
            ST_RD_BURST: begin
                if (issue) begin
                    pend_d      = 1'b1;
                    pend_last_d = beat_last;
                    if (beat_last) begin
                        issue_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end else if (load) begin
                    pend_d = 1'b0;
                end
                if (load) begin
                    rvalid_d = 1'b1;
                    rlast_d  = pend_last_q;
                    rresp_d  = err_q ? AXI_SLVERR : AXI_OKAY;
                    rdata_d  = err_q ? '0 : sram_rdata;
                end else if (r_hs) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                end
                if (r_hs && rlast_q) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    pend_d   = 1'b0;
                end
            end
            ST_WR_BURST: begin
                if (w_hs) begin
                    if (wlast_bad) begin
                        wlast_err_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d  = ST_WR_RESP;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q || wlast_err_q || wlast_bad) ? AXI_SLVERR : AXI_OKAY;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bvalid_q && axi.bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any burst but leaves storage intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            issue_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= AXI_OKAY;
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_OKAY;
            wlast_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            issue_done_q <= issue_done_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            wlast_err_q  <= wlast_err_d;
        end
    end

    assign axi.rvalid = rvalid_q;
    assign axi.rlast  = rlast_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;
    assign axi.bvalid = bvalid_q;
    assign axi.bresp  = bresp_q;

endmodule

// File: doc/hs_npu_axi_responder.md
HS_NPU_AXI_RESPONDER -- requirements
Module: hs_npu_axi_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, backing-store size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port axi  axib_if.s  bundle  AXI4 burst subordinate side (AR, R, AW, W, B channels; 32-bit data, 4-bit strobe).

Function
REQ-006 SHALL be the responder for the NPU memory-interface initiator, serving one INCR burst at a time from internal storage.
REQ-007 SHALL implement states IDLE, RD_BURST, WR_BURST, WR_RESP; reset state IDLE.
REQ-008 SHALL, in IDLE, drive awready=1 and arready=!awvalid (write wins a simultaneous request); both SHALL be 0 in all other states.
REQ-009 SHALL, on an AW handshake, latch awaddr and awlen, then go to WR_BURST; on an AR handshake, latch araddr and arlen, then go to RD_BURST.
REQ-010 SHALL compute word index = ((addr - BASE_ADDR) >> 2) + beat, modulo DEPTH_WORDS (wrap-around, no boundary error).
REQ-011 SHALL flag a burst as SLVERR when the start address is below BASE_ADDR, the start address is not 4-byte aligned, or size != 2; flagged reads return rdata=0 and flagged writes are discarded.
REQ-012 SHALL ignore arburst/awburst values and treat all bursts as INCR.
REQ-013 RD_BURST: first rvalid SHALL rise 2 cycles after the AR handshake edge; SHALL sustain one beat per cycle while rready=1.
REQ-014 RD_BURST: rdata/rlast/rresp SHALL hold stable while rvalid=1 and rready=0; no beat lost or duplicated.
REQ-015 RD_BURST: rlast=1 exactly on beat arlen; rresp=OKAY or SLVERR per burst; return to IDLE on the rlast handshake.
REQ-016 WR_BURST: wready SHALL be 1; each W handshake writes wdata bytes enabled by wstrb and increments the beat counter.
REQ-017 WR_BURST: burst SHALL end on beat awlen regardless of wlast; a wlast value mismatching the beat position SHALL set bresp=SLVERR without aborting the burst.
REQ-018 WR_RESP: bvalid=1 with latched bresp until the bready handshake, then IDLE; wready=0 in this state.
REQ-019 Beat counter SHALL be 8 bits (arlen/awlen 0..255) and SHALL never exceed the latched length.
REQ-020 Read-after-write: a read issued after a completed B handshake SHALL return the newly written data.

Reset
REQ-021 While rst=1: state=IDLE; rvalid=0, rlast=0, rdata=0, rresp=OKAY, bvalid=0, bresp=OKAY, arready=0, awready=0, wready=0; counters and error flags cleared.
REQ-022 Reset asserted mid-burst SHALL abandon the burst without a response; storage contents SHALL NOT be cleared.
REQ-023 First cycle after rst deasserts, IDLE readiness per REQ-008 SHALL apply.

Structure
REQ-024 uword, axi_resp_t (OKAY=2'b00, SLVERR=2'b10), AXI_SIZE_WORD=3'd2 and the INCR burst code SHALL live in hs_npu_pkg.
REQ-025 Storage SHALL be one sub-module hs_npu_sram: single-port, synchronous read (1-cycle), byte-enable write, DEPTH_WORDS x 32.
REQ-026 Read datapath SHALL use a one-entry skid register so SRAM reads advance only when the output slot frees.

Verification
REQ-027 Write awaddr=0x10, awlen=1, wdata={0xA5A5_0001,0xA5A5_0002}, wstrb=4'hF, bready=1 -> bvalid with bresp=OKAY; read araddr=0x10, arlen=1 -> rdata 0xA5A5_0001 then 0xA5A5_0002, rlast on beat 2, rresp=OKAY.
REQ-028 Same-cycle arvalid=awvalid=1 in IDLE -> awready=1, arready=0; the read is accepted only after bvalid/bready completes.
REQ-029 Read arlen=3 with rready toggling 1,0,0,1,... -> exactly 4 beats, data stable while stalled, rlast only on the 4th beat.
REQ-030 Write wstrb=4'b0101, wdata=0xFFFF_FFFF onto 0x1234_5678 -> read back 0x12FF_56FF.
REQ-031 Write address (DEPTH_WORDS-1)*4, awlen=1 -> second beat lands at word 0; araddr=0x2 -> both beats rresp=SLVERR, rdata=0.
REQ-032 rst=1 during beat 2 of an arlen=3 read -> next cycle rvalid=0, state IDLE; a subsequent read returns the stored data unchanged.
